special_reg_sequencer: RTL and testbench
========================================

Name: special_reg_sequencer

Overview:
Master-side controller for the special register file (PC, link, memory, flag). It takes simple control ops (step, jump, call, return, flag set, read) over a valid/ready handshake. It turns each op into one or two writes on the register file's single write port, and uses its combinational read port. It sits between instruction decode and the special register file, and is the only writer of that file.

Parameters:
DATA_W, 64, width of special registers and data paths
PC_STEP, 4, PC increment for STEP and link value for CALL
RESET_VECTOR, 64'h0, value written to PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
op_valid  in  1  op request
op_ready  out  1  sequencer accepts op this cycle
op_code  in  3  000 STEP, 001 JUMP, 010 CALL, 011 RET, 100 SETFLAG, 101 READ, 110/111 reserved
op_data  in  DATA_W  target (JUMP/CALL) or flag value (SETFLAG)
op_addr  in  3  special register address for READ
rsp_valid  out  1  one-cycle pulse, READ data available
rsp_data  out  DATA_W  READ result, held until next READ
srf_write_reg_addr  out  3  to register file write address
srf_write_data  out  DATA_W  to register file write data
srf_write_enable  out  1  to register file write enable
srf_read_reg_addr  out  3  to register file read address (combinational)
srf_read_data  in  DATA_W  from register file read data
srf_pc  in  DATA_W  from register file PC output

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- States: INIT, IDLE, WR1, WR2.
- Outputs while rst=1: state <= INIT, op_ready=0, rsp_valid=0, rsp_data=0, srf_write_enable=0, srf_write_reg_addr=0, srf_write_data=0.
- INIT (first cycle after rst falls):
  - Drives srf_write_enable=1, addr 000, data RESET_VECTOR, then moves to IDLE.
  - The register file has no reset; this write is the only PC initialisation.
- op_ready=1 only in IDLE. An op is accepted at an edge where op_valid&&op_ready.
- srf_read_reg_addr in IDLE: 001 when op_code=RET, op_addr when op_code=READ, else 000. Outside IDLE it is 000.
- Write-port outputs are registered. The write for an op accepted at edge N is driven in cycle N+1 and commits at edge N+1.
- Op handling:
  - STEP: WR1 writes PC <= srf_pc + PC_STEP, using srf_pc sampled at acceptance. Modulo 2^DATA_W, no wrap flag.
  - JUMP: WR1 writes PC <= op_data.
  - CALL: captures link = srf_pc + PC_STEP and target = op_data at acceptance. WR1 writes link reg (001) <= link. WR2 writes PC <= target. Busy for 2 cycles.
  - RET: captures srf_read_data (link reg) at acceptance. WR1 writes PC <= captured value.
  - SETFLAG: WR1 writes flag reg (011) <= op_data.
  - READ: rsp_data <= srf_read_data at acceptance. rsp_valid=1 in cycle N+1. No write. State goes to WR1 with srf_write_enable=0.
  - Reserved codes: accepted, no write, no response, one busy cycle.
- Every op leaves IDLE for at least one cycle. The next op is therefore always computed from committed register values, so there are no read-after-write hazards.
- srf_write_enable is 0 in IDLE. In WR1/WR2 it is 1 unless the op is READ or reserved.
- rst asserted mid-op (e.g. between the CALL link write and PC write): the pending write is dropped, then INIT rewrites PC.
- READ with op_addr 1xx returns 0 (register file behaviour).

Optional Feature:
SRF_CALL_DEPTH_EN
- Defined: adds outputs call_depth (8 bit) and ret_underflow (1 bit), both reset to 0.
  - call_depth increments when a CALL is accepted and saturates at 255.
  - call_depth decrements when a RET is accepted.
  - A RET accepted at depth 0 keeps depth at 0 and sets ret_underflow sticky until rst. The RET still executes.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_VECTOR=64'h1000 -> one INIT write of addr 000 data 64'h1000; srf_pc=64'h1000 afterwards; op_ready rises the following cycle.
- STEP x3 from PC=64'h1000 -> PC 64'h1004, 64'h1008, 64'h100C; op_ready low exactly one cycle after each acceptance.
- CALL target 64'h2000 at PC=64'h100C -> cycle N+1 writes 001<=64'h1010; cycle N+2 writes 000<=64'h2000; then RET -> PC=64'h1010.
- SETFLAG 64'hA5 then READ op_addr=011 -> rsp_valid one-cycle pulse with rsp_data=64'hA5; READ op_addr=110 -> rsp_data=0.
- rst asserted during WR1 of CALL -> link written at most once, PC write to target never happens, PC ends at RESET_VECTOR.
- STEP at PC=64'hFFFF_FFFF_FFFF_FFFC -> PC=64'h0; reserved op 3'b111 -> no srf_write_enable pulse, no rsp_valid.

Source files
------------

// File: rtl/special_reg_sequencer.sv
// Sequencer that turns control ops into writes on the special register file and services READs.
// Optional SRF_CALL_DEPTH_EN adds call-depth tracking outputs (call_depth, ret_underflow).
module special_reg_sequencer #(
   parameter int unsigned       DATA_W       = 64,
   parameter logic [DATA_W-1:0] PC_STEP      = DATA_W'(4),
   parameter logic [DATA_W-1:0] RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] op_data,
   input  logic [2:0]        op_addr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [2:0]        srf_write_reg_addr,
   output logic [DATA_W-1:0] srf_write_data,
   output logic              srf_write_enable,
   output logic [2:0]        srf_read_reg_addr,
   input  logic [DATA_W-1:0] srf_read_data,
   input  logic [DATA_W-1:0] srf_pc
`ifdef SRF_CALL_DEPTH_EN
   ,
   output logic [7:0]        call_depth,
   output logic              ret_underflow
`endif
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WR1  = 2'd2;
   localparam logic [1:0] ST_WR2  = 2'd3;

   localparam logic [2:0] OP_STEP    = 3'b000;
   localparam logic [2:0] OP_JUMP    = 3'b001;
   localparam logic [2:0] OP_CALL    = 3'b010;
   localparam logic [2:0] OP_RET     = 3'b011;
   localparam logic [2:0] OP_SETFLAG = 3'b100;
   localparam logic [2:0] OP_READ    = 3'b101;

   localparam logic [2:0] REG_PC   = 3'd0;
   localparam logic [2:0] REG_LINK = 3'd1;
   localparam logic [2:0] REG_FLAG = 3'd3;

   logic [1:0]        state_q, state_d;
   logic              init_wr_q, init_wr_d;
   logic              call_q, call_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic              wr_en_q, wr_en_d;
   logic [2:0]        wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              op_ready_q;

   assign op_ready           = op_ready_q;
   assign rsp_valid          = rsp_valid_q;
   assign rsp_data           = rsp_data_q;
   assign srf_write_enable   = wr_en_q;
   assign srf_write_reg_addr = wr_addr_q;
   assign srf_write_data     = wr_data_q;

   // Read port address must be valid in IDLE so RET/READ can sample at acceptance
   always_comb begin
      srf_read_reg_addr = REG_PC;
      if (state_q == ST_IDLE) begin
         if (op_code == OP_RET)       srf_read_reg_addr = REG_LINK;
         else if (op_code == OP_READ) srf_read_reg_addr = op_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_wr_q   <= 1'b0;
         call_q      <= 1'b0;
         target_q    <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         op_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_wr_q   <= init_wr_d;
         call_q      <= call_d;
         target_q    <= target_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         op_ready_q  <= (state_d == ST_IDLE);
      end
   end

   // Next state and the registered write/response payload for the following cycle
   always_comb begin
      state_d     = state_q;
      init_wr_d   = init_wr_q;
      call_d      = call_q;
      target_d    = target_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         ST_INIT: begin
            // The register file has no reset: the PC load is staged, driven, then IDLE
            if (!init_wr_q) begin
               init_wr_d = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = REG_PC;
               wr_data_d = RESET_VECTOR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (op_valid) begin
               state_d = ST_WR1;
               call_d  = 1'b0;
               case (op_code)
                  OP_STEP: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = REG_PC;
                     wr_data_d = srf_pc + PC_STEP;
                  end
                  OP_JUMP: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = REG_PC;
                     wr_data_d = op_data;
                  end
                  OP_CALL: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = REG_LINK;
                     wr_data_d = srf_pc + PC_STEP;
                     target_d  = op_data;
                     call_d    = 1'b1;
                  end
                  OP_RET: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = REG_PC;
                     wr_data_d = srf_read_data;
                  end
                  OP_SETFLAG: begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = REG_FLAG;
                     wr_data_d = op_data;
                  end
                  OP_READ: begin
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = srf_read_data;
                  end
                  default: ;
               endcase
            end
         end
         ST_WR1: begin
            call_d = 1'b0;
            if (call_q) begin
               state_d   = ST_WR2;
               wr_en_d   = 1'b1;
               wr_addr_d = REG_PC;
               wr_data_d = target_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR2:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SRF_CALL_DEPTH_EN
   // Depth saturates at 255; a RET at depth 0 flags underflow but still executes
   always_ff @(posedge clk) begin
      if (rst) begin
         call_depth    <= '0;
         ret_underflow <= 1'b0;
      end else if (op_valid && op_ready_q) begin
         if (op_code == OP_CALL && call_depth != 8'hFF) begin
            call_depth <= call_depth + 8'd1;
         end else if (op_code == OP_RET) begin
            if (call_depth == 8'd0) ret_underflow <= 1'b1;
            else                    call_depth    <= call_depth - 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_special_reg_sequencer.sv
// Bench for special_reg_sequencer: vector table plus write/response scoreboard against a register file model.
module tb_special_reg_sequencer;

   localparam int unsigned DATA_W = 64;
   localparam logic [63:0] RV     = 64'h1000;
   localparam logic [63:0] STEP   = 64'd4;

   typedef struct packed {
      logic [2:0]  addr;
      logic [63:0] data;
   } wr_t;

   typedef struct {
      logic [2:0]  code;
      logic [63:0] data;
      logic [2:0]  addr;
      int          busy;
      logic [63:0] exp_pc;
      logic [63:0] exp_rsp;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [63:0]       op_data;
   logic [2:0]        op_addr;
   logic              rsp_valid;
   logic [63:0]       rsp_data;
   logic [2:0]        srf_write_reg_addr;
   logic [63:0]       srf_write_data;
   logic              srf_write_enable;
   logic [2:0]        srf_read_reg_addr;
   logic [63:0]       srf_read_data;
   logic [63:0]       srf_pc;
`ifdef SRF_CALL_DEPTH_EN
   logic [7:0]        call_depth;
   logic              ret_underflow;
`endif

   int checks = 0;
   int errors = 0;

   wr_t         exp_wr[$];
   logic [63:0] exp_rsp[$];
   logic [63:0] m_pc, m_link, m_mem, m_flag;

   // Register file model: no reset, combinational reads, 1xx reads as zero
   logic [63:0] rf [4] = '{64'hDEAD_0000, 64'h1111, 64'hBEEF, 64'h3333};

   always @(posedge clk)
      if (srf_write_enable === 1'b1 && !srf_write_reg_addr[2])
         rf[srf_write_reg_addr[1:0]] <= srf_write_data;

   assign srf_read_data = srf_read_reg_addr[2] ? 64'h0 : rf[srf_read_reg_addr[1:0]];
   assign srf_pc        = rf[0];

   special_reg_sequencer #(
      .DATA_W      (DATA_W),
      .PC_STEP     (STEP),
      .RESET_VECTOR(RV)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .op_valid          (op_valid),
      .op_ready          (op_ready),
      .op_code           (op_code),
      .op_data           (op_data),
      .op_addr           (op_addr),
      .rsp_valid         (rsp_valid),
      .rsp_data          (rsp_data),
      .srf_write_reg_addr(srf_write_reg_addr),
      .srf_write_data    (srf_write_data),
      .srf_write_enable  (srf_write_enable),
      .srf_read_reg_addr (srf_read_reg_addr),
      .srf_read_data     (srf_read_data),
      .srf_pc            (srf_pc)
`ifdef SRF_CALL_DEPTH_EN
      ,
      .call_depth        (call_depth),
      .ret_underflow     (ret_underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every write and response the DUT produces must match the queue head
   always @(negedge clk) begin
      if (srf_write_enable === 1'b1) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_write", {61'd0, srf_write_reg_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("write_addr", {61'd0, srf_write_reg_addr}, {61'd0, w.addr});
            chk("write_data", srf_write_data, w.data);
         end
      end
      if (rsp_valid === 1'b1) begin
         if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_data, ~rsp_data);
         else                     chk("rsp_data_pulse", rsp_data, exp_rsp.pop_front());
      end
   end

   function automatic logic [63:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_pc;
         3'd1:    return m_link;
         3'd2:    return m_mem;
         3'd3:    return m_flag;
         default: return 64'h0;
      endcase
   endfunction

   task automatic push_wr(input logic [2:0] a, input logic [63:0] d);
      exp_wr.push_back({a, d});
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (op_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, {63'd0, op_ready}, 64'd1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_op_ready", {63'd0, op_ready}, 64'd0);
      chk("rst_wr_en", {63'd0, srf_write_enable}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_wr_addr", {61'd0, srf_write_reg_addr}, 64'd0);
      chk("rst_wr_data", srf_write_data, 64'd0);
   endtask

   // Issues one op at a negedge with op_ready high; returns the number of busy cycles
   task automatic run_op(input logic [2:0] code, input logic [63:0] data,
                         input logic [2:0] addr, output int busy);
      wait_ready("op_ready_wait");
      case (code)
         3'b000: begin push_wr(3'd0, m_pc + STEP); m_pc = m_pc + STEP; end
         3'b001: begin push_wr(3'd0, data); m_pc = data; end
         3'b010: begin
            push_wr(3'd1, m_pc + STEP);
            push_wr(3'd0, data);
            m_link = m_pc + STEP;
            m_pc   = data;
         end
         3'b011: begin push_wr(3'd0, m_link); m_pc = m_link; end
         3'b100: begin push_wr(3'd3, data); m_flag = data; end
         3'b101: exp_rsp.push_back(model_read(addr));
         default: ;
      endcase
      op_valid = 1'b1;
      op_code  = code;
      op_data  = data;
      op_addr  = addr;
      @(posedge clk);
      #1 op_valid = 1'b0;
      busy = 0;
      @(negedge clk);
      while (op_ready !== 1'b1 && busy < 10) begin
         busy++;
         @(negedge clk);
      end
   endtask

   vec_t vecs[16];

   initial begin
      int busy;
      vecs[0]  = '{3'b000, 64'h0,                   3'd0, 1, 64'h1004,                0};
      vecs[1]  = '{3'b000, 64'h0,                   3'd0, 1, 64'h1008,                0};
      vecs[2]  = '{3'b000, 64'h0,                   3'd0, 1, 64'h100C,                0};
      vecs[3]  = '{3'b010, 64'h2000,                3'd0, 2, 64'h2000,                0};
      vecs[4]  = '{3'b011, 64'h0,                   3'd0, 1, 64'h1010,                0};
      vecs[5]  = '{3'b100, 64'hA5,                  3'd0, 1, 64'h1010,                0};
      vecs[6]  = '{3'b101, 64'h0,                   3'd3, 1, 64'h1010,                64'hA5};
      vecs[7]  = '{3'b101, 64'h0,                   3'd6, 1, 64'h1010,                0};
      vecs[8]  = '{3'b101, 64'h0,                   3'd2, 1, 64'h1010,                64'hBEEF};
      vecs[9]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hBEEF};
      vecs[10] = '{3'b000, 64'h0,                   3'd0, 1, 64'h0,                   64'hBEEF};
      vecs[11] = '{3'b111, 64'h55,                  3'd0, 1, 64'h0,                   64'hBEEF};
      vecs[12] = '{3'b101, 64'h0,                   3'd1, 1, 64'h0,                   64'h1010};
      vecs[13] = '{3'b110, 64'h77,                  3'd3, 1, 64'h0,                   64'h1010};
      vecs[14] = '{3'b100, 64'h5A,                  3'd0, 1, 64'h0,                   64'h1010};
      vecs[15] = '{3'b101, 64'h0,                   3'd3, 1, 64'h0,                   64'h5A};

      m_pc = 64'hDEAD_0000; m_link = 64'h1111; m_mem = 64'hBEEF; m_flag = 64'h3333;
      rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_data = 64'd0; op_addr = 3'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs();

      // Reset release: single PC load of the reset vector, then ready
      push_wr(3'd0, RV);
      m_pc = RV;
      rst  = 1'b0;
      wait_ready("init_ready");
      chk("init_pc", srf_pc, RV);
      chk("init_write_seen", 64'(exp_wr.size()), 64'd0);

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].code, vecs[i].data, vecs[i].addr, busy);
         chk($sformatf("busy_cycles[%0d]", i), 64'(busy), 64'(vecs[i].busy));
         chk($sformatf("pc[%0d]", i), srf_pc, vecs[i].exp_pc);
         chk($sformatf("rsp_hold[%0d]", i), rsp_data, vecs[i].exp_rsp);
         chk($sformatf("writes_done[%0d]", i), 64'(exp_wr.size()), 64'd0);
         chk($sformatf("rsp_done[%0d]", i), 64'(exp_rsp.size()), 64'd0);
      end

      // Reset during the link write of a CALL: target write must never happen
      wait_ready("call_rst_ready");
      push_wr(3'd1, m_pc + STEP);
      m_link   = m_pc + STEP;
      op_valid = 1'b1;
      op_code  = 3'b010;
      op_data  = 64'h3000;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      chk("call_rst_link_once", 64'(exp_wr.size()), 64'd0);
      push_wr(3'd0, RV);
      m_pc = RV;
      rst  = 1'b0;
      wait_ready("call_rst_init_ready");
      chk("call_rst_pc", srf_pc, RV);
      chk("call_rst_link", rf[1], m_link);
      chk("call_rst_writes_done", 64'(exp_wr.size()), 64'd0);
      chk("call_rst_rsp_data", rsp_data, 64'd0);

      // One more STEP after the mid-op reset
      run_op(3'b000, 64'h0, 3'd0, busy);
      chk("post_rst_busy", 64'(busy), 64'd1);
      chk("post_rst_pc", srf_pc, RV + STEP);

      repeat (3) @(negedge clk);
      chk("final_writes_done", 64'(exp_wr.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
